ps2_z88_keymatrix: RTL



---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_z88_keymap.sv | 41 ++++
 rtl/ps2_z88_keymatrix.sv | 115 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 to Z88 keyboard matrix controller:
// decoder states, PS/2 protocol byte values and matrix geometry.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } kb_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = 3;
    localparam int COL_W = 3;

    // Keyboard controller replies that carry no key information.
    function automatic logic is_ctrl_resp(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

    function automatic logic is_ovr_code(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_z88_keymap.sv
// Combinational map from {extended flag, set-2 scancode} to a Z88 matrix
// position; the table entries are written as octal {row,col} pairs.
module ps2_z88_keymap
    import ps2_pkg::*;
(
    input  logic [8:0]       key,
    output logic             hit,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    logic [5:0] rc;

    always_comb begin
        hit = 1'b1;
        rc  = 6'o00;
        case (key)
            9'h03D: rc = 6'o00;  9'h03B: rc = 6'o01;  9'h031: rc = 6'o02;  9'h033: rc = 6'o03;
            9'h035: rc = 6'o04;  9'h036: rc = 6'o05;  9'h05A: rc = 6'o06;  9'h066: rc = 6'o07;
            9'h03E: rc = 6'o10;  9'h042: rc = 6'o11;  9'h03A: rc = 6'o12;  9'h034: rc = 6'o13;
            9'h03C: rc = 6'o14;  9'h02E: rc = 6'o15;  9'h029: rc = 6'o16;  9'h175: rc = 6'o17;
            9'h046: rc = 6'o20;  9'h043: rc = 6'o21;  9'h041: rc = 6'o22;  9'h02B: rc = 6'o23;
            9'h02C: rc = 6'o24;  9'h025: rc = 6'o25;  9'h00D: rc = 6'o26;  9'h172: rc = 6'o27;
            9'h045: rc = 6'o30;  9'h01C: rc = 6'o31;  9'h049: rc = 6'o32;  9'h023: rc = 6'o33;
            9'h02D: rc = 6'o34;  9'h026: rc = 6'o35;  9'h076: rc = 6'o36;  9'h16B: rc = 6'o37;
            9'h04E: rc = 6'o40;  9'h044: rc = 6'o41;  9'h04A: rc = 6'o42;  9'h024: rc = 6'o43;
            9'h01B: rc = 6'o44;  9'h01E: rc = 6'o45;  9'h00E: rc = 6'o46;  9'h174: rc = 6'o47;
            9'h055: rc = 6'o50;  9'h04D: rc = 6'o51;  9'h04C: rc = 6'o52;  9'h01D: rc = 6'o53;
            9'h022: rc = 6'o54;  9'h016: rc = 6'o55;  9'h011: rc = 6'o56;  9'h014: rc = 6'o57;
            9'h05D: rc = 6'o60;  9'h054: rc = 6'o61;  9'h052: rc = 6'o62;  9'h015: rc = 6'o63;
            9'h01A: rc = 6'o64;  9'h021: rc = 6'o65;  9'h012: rc = 6'o66;  9'h059: rc = 6'o67;
            9'h05B: rc = 6'o70;  9'h04B: rc = 6'o71;  9'h058: rc = 6'o72;  9'h02A: rc = 6'o73;
            9'h032: rc = 6'o74;  9'h005: rc = 6'o75;  9'h006: rc = 6'o76;  9'h004: rc = 6'o77;
            default: hit = 1'b0;
        endcase
    end

    assign row = rc[5:3];
    assign col = rc[2:0];

endmodule

// File: rtl/ps2_z88_keymatrix.sv
// PS/2 scancode sequencer that maintains the Z88 8x8 key matrix, answers
// active-low row-select port reads and owns the Caps Lock LED state.
module ps2_z88_keymatrix #(
    parameter int         PAUSE_SKIP = 7,
    parameter logic [7:0] CAPS_CODE  = 8'h58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_vld,
    input  logic [7:0] kb_data,
    input  logic [7:0] row_sel,
    output logic [7:0] col_out,
    output logic       caps_led,
    output logic       key_any,
    output logic       overrun,
    input  logic       ovr_clr
);
    import ps2_pkg::*;

    kb_state_t                   state;
    logic                        vld_q;
    logic                        cap_vld;
    logic [7:0]                  cap;
    logic [3:0]                  skip;
    logic [ROWS-1:0][COLS-1:0]   matrix;
    logic                        lk_ext;
    logic                        lk_hit;
    logic [ROW_W-1:0]            lk_row;
    logic [COL_W-1:0]            lk_col;
    logic                        caps_new;
    logic [COLS-1:0]             sel_cols;

    assign lk_ext = (state == ST_EXT) || (state == ST_EXT_BRK);

    ps2_z88_keymap u_keymap (
        .key ({lk_ext, cap}),
        .hit (lk_hit),
        .row (lk_row),
        .col (lk_col)
    );

    // Typematic repeats of Caps Lock arrive with the key bit already set.
    assign caps_new = !lk_ext && (cap == CAPS_CODE) && !(lk_hit && matrix[lk_row][lk_col]);

    always_comb begin
        sel_cols = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_sel[r]) sel_cols = sel_cols | matrix[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vld_q    <= 1'b0;
            cap_vld  <= 1'b0;
            cap      <= 8'h00;
            skip     <= 4'd0;
            matrix   <= '0;
            col_out  <= 8'hFF;
            caps_led <= 1'b0;
            key_any  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            vld_q   <= kb_vld;
            cap_vld <= kb_vld && !vld_q;
            if (kb_vld && !vld_q) cap <= kb_data;
            col_out <= ~sel_cols;
            key_any <= |matrix;
            if (ovr_clr) overrun <= 1'b0;

            if (cap_vld) begin
                if (state != ST_PAUSE && is_ovr_code(cap)) begin
                    matrix <= '0;
                    if (!ovr_clr) overrun <= 1'b1;
                    state  <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (cap == PS2_EXT) begin
                                state <= ST_EXT;
                            end else if (cap == PS2_BRK) begin
                                state <= ST_BRK;
                            end else if (cap == PS2_PAUSE) begin
                                state <= ST_PAUSE;
                                skip  <= 4'(PAUSE_SKIP);
                            end else if (!is_ctrl_resp(cap)) begin
                                if (lk_hit) matrix[lk_row][lk_col] <= 1'b1;
                                if (caps_new) caps_led <= ~caps_led;
                            end
                        end
                        ST_EXT: begin
                            if (cap == PS2_BRK) begin
                                state <= ST_EXT_BRK;
                            end else if (cap != PS2_EXT) begin
                                if (lk_hit) matrix[lk_row][lk_col] <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                        ST_BRK, ST_EXT_BRK: begin
                            if (lk_hit) matrix[lk_row][lk_col] <= 1'b0;
                            state <= ST_IDLE;
                        end
                        ST_PAUSE: begin
                            skip <= skip - 4'd1;
                            if (skip <= 4'd1) state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
